up_down_counter: RTL and testbench

Parameterised n-bit synchronous binary counter with count enable, direction select and parallel load. It is a general-purpose building block for address generators, tick dividers and loop counters. It is a single registered state vector with combinational next-state logic, and it wraps modulo 2^n in both directions.

---
 rtl/up_down_counter_pkg.sv | 17 +
 rtl/up_down_counter_next.sv | 36 +++
 rtl/up_down_counter.sv | 61 ++++++
 tb/tb_up_down_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared definitions for the up_down_counter slice: default width, direction
// encoding and the all-ones terminal value helper.
package up_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Valid for widths 1..32; the value is right-aligned in a 32-bit word.
  function automatic logic [31:0] terminal_value(input int width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/up_down_counter_next.sv
// Combinational next-state logic for up_down_counter: load has priority over
// counting, and counting wraps modulo 2^n in both directions.
module up_down_counter_next
  import up_down_counter_pkg::*;
#(
  parameter int n = DEFAULT_WIDTH
) (
  input  logic [n-1:0] q,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [n-1:0] d,
  output logic [n-1:0] q_next
);

  localparam logic [n-1:0] ONE = n'(1);

  dir_e dir;

  assign dir = dir_e'(up);

  // Carry and borrow fall off the top bit, which gives the modulo wrap for free.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = d;
    end else if (en) begin
      if (dir == DIR_UP) begin
        q_next = q + ONE;
      end else begin
        q_next = q - ONE;
      end
    end
  end

endmodule

// File: rtl/up_down_counter.sv
// n-bit up/down counter with enable and parallel load; the terminal-count
// output tc exists only when UP_DOWN_COUNTER_TC_EN is defined.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int n = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [n-1:0] D,
`ifdef UP_DOWN_COUNTER_TC_EN
  output logic [n-1:0] Q,
  output logic         tc
`else
  output logic [n-1:0] Q
`endif
);

  logic [n-1:0] qNext;

  up_down_counter_next #(
    .n(n)
  ) u_next (
    .q     (Q),
    .en    (en),
    .up    (up),
    .load  (load),
    .d     (D),
    .q_next(qNext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q <= '0;
    end else begin
      Q <= qNext;
    end
  end

`ifdef UP_DOWN_COUNTER_TC_EN
  localparam logic [31:0]  TERM_FULL = terminal_value(n);
  localparam logic [n-1:0] TERM      = TERM_FULL[n-1:0];
  localparam logic [n-1:0] ZERO      = '0;

  // tc flags the step that is about to wrap; a pending load suppresses it.
  always_comb begin
    tc = 1'b0;
    if (reset_n && en && !load) begin
      if (dir_e'(up) == DIR_UP) begin
        tc = (Q == TERM);
      end else begin
        tc = (Q == ZERO);
      end
    end
  end
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter (n = 4): directed vector table,
// async-reset sequence, then random stimulus against a modulo-arithmetic model.
module tb_up_down_counter;

  localparam int N   = 4;
  localparam int MOD = 1 << N;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] D = '0;
  logic [N-1:0] Q;
`ifdef UP_DOWN_COUNTER_TC_EN
  logic         tc;
`endif

  int checkCount = 0;
  int passCount = 0;
  int modelQ = 0;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    int         expQ;
    string      name;
  } vec_t;

  vec_t vecs[$];

  up_down_counter #(
    .n(N)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .up     (up),
    .load   (load),
    .D      (D),
`ifdef UP_DOWN_COUNTER_TC_EN
    .Q      (Q),
    .tc     (tc)
`else
    .Q      (Q)
`endif
  );

  always #5 clk = ~clk;

  // Compares Q with an expected value and records the result.
  task automatic checkOutput(input string name, input int expQ);
    checkCount++;
    if (int'(Q) == expQ) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: Q=%0d expected %0d", name, Q, expQ);
    end
  endtask

  // Drives one cycle of controls, checks tc before the edge, then advances
  // the reference model across the edge. Called just after a rising edge.
  task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [N-1:0] d);
    en = e;
    up = u;
    load = l;
    D = d;
    #1;
`ifdef UP_DOWN_COUNTER_TC_EN
    begin
      logic expTc;
      expTc = e && !l && ((u && modelQ == MOD - 1) || (!u && modelQ == 0));
      checkCount++;
      if (tc === expTc) passCount++;
      else $display("[TB] FAIL tc: tc=%b expected %b (Q=%0d en=%b up=%b load=%b)", tc, expTc, Q, e, u, l);
    end
`endif
    @(posedge clk);
    #1;
    if (l) modelQ = int'(d);
    else if (e && u) modelQ = (modelQ + 1) % MOD;
    else if (e) modelQ = (modelQ - 1 + MOD) % MOD;
  endtask

  initial begin
    vec_t v;

    for (int i = 1; i <= 15; i++) begin
      v = '{1'b1, 1'b1, 1'b0, 4'd0, i, $sformatf("count_up_%0d", i)};
      vecs.push_back(v);
    end
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 15, "hold15_a"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 15, "hold15_b"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 0,  "wrap_up"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 15, "wrap_down"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 14, "down_14"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 13, "down_13"});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd9, 9,  "load_over_count"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd2, 8,  "down_after_load"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd5, 7,  "down_7"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd3, 3,  "load_no_en"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd12, 3, "hold_ignores_d"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd15, 15, "load_15"});

    reset_n = 1'b0;
    #1;
    checkOutput("reset_immediate", 0);
    #1;
    reset_n = 1'b1;
    modelQ = 0;

    @(posedge clk);
    #1;
    checkOutput("hold_after_reset_1", 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("hold_after_reset_2", 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].d);
      checkOutput(vecs[i].name, vecs[i].expQ);
    end

    // Async reset mid-count: Q must clear between edges, then resume from 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("pre_reset_count", 14);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_count", 0);
    modelQ = 0;
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_edge_after_reset", 15);
    modelQ = 15;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("up_after_reset", 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("up_after_reset_2", 1);

    // Random stimulus; D is left unknown on cycles without load.
    for (int i = 0; i < 300; i++) begin
      logic re, ru, rl;
      logic [N-1:0] rd;
      re = 1'($urandom_range(0, 3) != 0);
      ru = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 5) == 0);
      rd = rl ? N'($urandom_range(0, MOD - 1)) : 'x;
      applyStimulus(re, ru, rl, rd);
      checkOutput($sformatf("random_%0d", i), modelQ);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
